// File: rtl/ex_core_alu.sv
// ex_core_alu: RV32I integer ALU with combinational result/zero and a one-cycle registered copy
module ex_core_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] result_q,
    output logic        zero_q
);
    logic [4:0]  shamt;
    logic [31:0] sra;
    assign shamt = operand2[4:0];
    // kept as its own assignment so the arithmetic shift stays signed outside the unsigned select chain
    assign sra = $signed(operand1) >>> shamt;
    // operation select; undefined opcodes fall through to zero
    always_comb begin
        result = op == 4'd0 ? operand1 + operand2 :
                 op == 4'd1 ? operand1 - operand2 :
                 op == 4'd2 ? operand1 & operand2 :
                 op == 4'd3 ? operand1 | operand2 :
                 op == 4'd4 ? operand1 ^ operand2 :
                 op == 4'd5 ? operand1 << shamt :
                 op == 4'd6 ? operand1 >> shamt :
                 op == 4'd7 ? sra :
                 op == 4'd8 ? {31'd0, $signed(operand1) < $signed(operand2)} :
                 op == 4'd9 ? {31'd0, operand1 < operand2} :
                 32'd0;
        zero = result == 32'd0;
    end
    // capture stage; reset forces the zero-result state immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end
endmodule

// File: tb/tb_ex_core_alu.sv
// tb_ex_core_alu: randomized and directed checks of ex_core_alu against a behavioural model
module tb_ex_core_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic [3:0]  op = 4'd0;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
    int checks = 0;
    int errors = 0;

    ex_core_alu dut (
        .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2), .op(op),
        .result(result), .zero(zero), .result_q(result_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p = longint'(1) << (b % 32);
        case (o)
            4'd0: return 32'(ua + ub);
            4'd1: return 32'(ua - ub);
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return 32'(ua * p);
            4'd6: return 32'(ua / p);
            4'd7: return 32'((sa < 0 ? sa - (p - 1) : sa) / p);
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (ua < ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        op = 4'd0; operand1 = 32'd9; operand2 = 32'd1;
        @(posedge clk); #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold result_q=%h zero_q=%b want 00000000/1", result_q, zero_q);
        end
        checks++;
        if (result !== 32'd10 || zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_in_reset result=%h zero=%b want 0000000a/0", result, zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_directed(input string name, input logic [3:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        op = o; operand1 = a; operand2 = b;
        #1;
        checks++;
        if (result !== exp || zero !== (exp == 32'd0)) begin
            errors++;
            $display("FAIL %s result=%h zero=%b want %h/%b", name, result, zero, exp, exp == 32'd0);
        end
    endtask

    task automatic test_arith();
        run_directed("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_directed("sub_neg", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
        run_directed("sub_eq", 4'd1, 32'd7, 32'd7, 32'd0);
    endtask

    task automatic test_logic();
        run_directed("and", 4'd2, 32'b1010, 32'b0110, 32'b0010);
        run_directed("or", 4'd3, 32'b1010, 32'b0110, 32'b1110);
        run_directed("xor", 4'd4, 32'b1010, 32'b0110, 32'b1100);
    endtask

    task automatic test_shift();
        run_directed("sll31", 4'd5, 32'd1, 32'd31, 32'h8000_0000);
        run_directed("srl4", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_directed("sra4", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_directed("sll_amt32", 4'd5, 32'd5, 32'h20, 32'd5);
        run_directed("sra_amt0", 4'd7, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
        run_directed("srl_hi_ign", 4'd6, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000);
    endtask

    task automatic test_compare();
        run_directed("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_directed("sltu_big", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_directed("slt_eq", 4'd8, 32'd4, 32'd4, 32'd0);
        run_directed("sltu_lt", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 9));
            operand1 = i < 20 ? $urandom_range(0, 10) : $urandom;
            operand2 = i < 20 ? $urandom_range(0, 10) : $urandom;
            exp = model(op, operand1, operand2);
            #1;
            checks++;
            if (result !== exp || zero !== (exp == 32'd0)) begin
                errors++;
                $display("FAIL rand_comb op=%0d a=%h b=%h result=%h zero=%b want %h", op, operand1, operand2, result, zero, exp);
            end
            @(posedge clk); #1;
            checks++;
            if (result_q !== exp || zero_q !== (exp == 32'd0)) begin
                errors++;
                $display("FAIL rand_reg op=%0d result_q=%h zero_q=%b want %h", op, result_q, zero_q, exp);
            end
        end
    endtask

    task automatic test_undefined();
        for (int o = 10; o < 16; o++) begin
            op = 4'(o); operand1 = $urandom | 32'd1; operand2 = $urandom | 32'd1;
            #1;
            checks++;
            if (result !== 32'd0 || zero !== 1'b1) begin
                errors++;
                $display("FAIL undef_op%0d result=%h zero=%b want 00000000/1", o, result, zero);
            end
        end
    endtask

    task automatic test_regstage();
        @(negedge clk);
        op = 4'd0; operand1 = 32'd2; operand2 = 32'd3;
        @(posedge clk); #1;
        checks++;
        if (result_q !== 32'd5 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL reg_capture result_q=%h zero_q=%b want 00000005/0", result_q, zero_q);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            errors++;
            $display("FAIL async_reset result_q=%h zero_q=%b want 00000000/1", result_q, zero_q);
        end
        checks++;
        if (result !== 32'd5 || zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_during_rst result=%h zero=%b want 00000005/0", result, zero);
        end
        @(posedge clk); #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_edge result_q=%h zero_q=%b want 00000000/1", result_q, zero_q);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            errors++;
            $display("FAIL early_capture result_q=%h zero_q=%b want 00000000/1", result_q, zero_q);
        end
        @(posedge clk); #1;
        checks++;
        if (result_q !== 32'd5 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL first_capture result_q=%h zero_q=%b want 00000005/0", result_q, zero_q);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_compare();
        test_undefined();
        test_random();
        test_regstage();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_core_alu.md
# ex_core_alu

Integer ALU of the ex_core execute stage. It implements the ten RV32I register/immediate ALU operations on two 32-bit operands and produces a combinational result plus a zero flag. The same result and flag are also captured in a one-cycle register stage for downstream consumers. Branch/compare logic uses `zero`; write-back uses `result` or `result_q`.

## Interface
- No parameters; data width fixed at 32.
- Clk  in  1  clock; the only clock; registers update on its rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- operand1  in  32  first source operand (rs1 value).
- operand2  in  32  second source operand (rs2 value or immediate); bits [4:0] are the shift amount.
- op  in  4  operation select (encoding below).
- result  out  32  combinational ALU result.
- zero  out  1  combinational; 1 when result == 32'h0.
- result_q  out  32  result registered on Clk.
- zero_q  out  1  zero registered on Clk.

## Operation
- Opcode encoding and result:
  - 4'b0000 ADD: operand1 + operand2, modulo 2^32; carry discarded.
  - 4'b0001 SUB: operand1 - operand2, modulo 2^32; borrow discarded.
  - 4'b0010 AND: bitwise AND.
  - 4'b0011 OR: bitwise OR.
  - 4'b0100 XOR: bitwise XOR.
  - 4'b0101 SLL: operand1 << operand2[4:0]; zero fill.
  - 4'b0110 SRL: operand1 >> operand2[4:0]; zero fill.
  - 4'b0111 SRA: operand1 >>> operand2[4:0]; fill with operand1[31].
  - 4'b1000 SLT: 32'd1 if $signed(operand1) < $signed(operand2), else 32'd0.
  - 4'b1001 SLTU: 32'd1 if operand1 < operand2 unsigned, else 32'd0.
  - 4'b1010–4'b1111 (undefined): result = 32'h0, so zero = 1. No X is ever propagated.
- Shifts use only operand2[4:0]; operand2[31:5] is ignored. A shift amount of 0 returns operand1 unchanged.
- zero is derived from the final result for every op, including undefined ops.
- result and zero are purely combinational from operand1/operand2/op, with no dependency on Clk or Rst.

## Timing
- result and zero are valid one combinational settle delay after any input change. There is zero-cycle latency and no handshake.
- result_q and zero_q take the values of result and zero at each rising Clk edge, giving one-cycle latency.
- Rst asserted: result_q = 32'h0 and zero_q = 1 immediately, without waiting for Clk. They hold these values while Rst is high.
- First capture of live data is at the first rising Clk edge after Rst deasserts.
- Rst does not affect the combinational outputs. Asserting Rst mid-stream discards the pending capture only.

## Test plan
- Arithmetic wrap: ADD with 32'hFFFF_FFFF + 32'h1 -> result 0, zero 1. SUB with 3 - 5 -> 32'hFFFF_FFFE, zero 0. SUB with 7 - 7 -> 0, zero 1.
- Logic ops on 4'b1010 / 4'b0110: AND -> 4'b0010, OR -> 4'b1110, XOR -> 4'b1100.
- Shifts:
  - SLL 1 by 31 -> 32'h8000_0000.
  - SRL 32'h8000_0000 by 4 -> 32'h0800_0000.
  - SRA 32'h8000_0000 by 4 -> 32'hF800_0000.
  - SLL 5 with operand2 = 32'h20 -> 5, because only bits [4:0] are used.
- Compares:
  - SLT 32'hFFFF_FFFF vs 1 -> 1.
  - SLTU on the same operands -> 0.
  - SLT 4 vs 4 -> 0, zero 1.
- Random sweep: 15+ iterations with operands in 0..10 and op in 0..9. Check result against a reference model after settle. Also drive op 10–15 -> result 0, zero 1.
- Register stage and reset:
  - Assert Rst asynchronously between edges -> result_q 0 and zero_q 1 at once.
  - Release Rst, apply ADD 2+3 -> result_q 5 and zero_q 0 after the next rising edge, not before.
